sw_input_port: RTL and testbench
================================

// Module: sw_input_port
// PURPOSE
//   Receiving end of the switch/button operand-entry interface of the picoMIPS cpu.
//   Synchronises and debounces the SW8 "enter" button and the SW operand switches.
//   On each accepted SW8 press it captures the SW value into a small FIFO, which
//   the processor core drains with a valid/read handshake.
//   The core receives one 8-bit signed operand per press (e.g. X1 then Y1), in entry order.
// PARAMETERS
//   WIDTH            8   operand width (SW and rd_data)
//   SYNC_STAGES      2   synchroniser flops on SW and SW8 (>=2)
//   DEBOUNCE_CYCLES  2   consecutive differing synced samples before the button level changes (>=1)
//   DEPTH            2   FIFO entries (power of 2, >=2)
// PORTS
//   clk       in   1                      system clock; all state on rising edge
//   reset     in   1                      synchronous, active-high reset
//   SW        in   WIDTH                  asynchronous operand switches, signed two's complement
//   SW8       in   1                      asynchronous enter button, active high
//   rd_en     in   1                      core pops head entry this cycle
//   rd_data   out  WIDTH                  FIFO head operand, bit-exact copy of captured SW
//   rd_valid  out  1                      FIFO non-empty
//   level     out  $clog2(DEPTH+1)        number of stored entries
//   overflow  out  1                      sticky: a press was dropped because the FIFO was full
// BEHAVIOUR
//   Reset (reset=1 at a clock edge)
//   - Clears sync chains, debounce counter, debounced level, FIFO pointers, level and overflow.
//   - rd_valid=0, rd_data=0. Reset overrides every other event in that cycle.
//   - Reset mid-debounce aborts the pending press; no push occurs.
//   Synchronisation
//   - SW and SW8 each pass through SYNC_STAGES flops, giving sw_s and b_s.
//   Debounce
//   - State: deb (debounced level) and cnt.
//   - If b_s==deb: cnt<=0.
//   - Else if cnt==DEBOUNCE_CYCLES-1: deb<=b_s and cnt<=0.
//   - Else: cnt<=cnt+1.
//   - Net effect: b_s must differ from deb for DEBOUNCE_CYCLES consecutive cycles.
//   Press detect
//   - push is asserted in the cycle where deb updates 0->1; it writes sw_s into the FIFO at that edge.
//   - Release (1->0) never pushes.
//   - Latency: SW8 high sampled at edge 1 gives rd_valid=1 after edge SYNC_STAGES+DEBOUNCE_CYCLES
//     (edge 4 with defaults).
//   - SW must be stable SYNC_STAGES cycles before the press completes debounce.
//   FIFO
//   - Circular buffer with wr/rd pointers wrapping modulo DEPTH.
//   - rd_data is the head entry, valid whenever rd_valid=1.
//   - Pop: rd_en && rd_valid advances the head; rd_en while empty is ignored with no state change.
//   - Push while not full stores the entry; level increments.
//   - Push while full and no pop: entry dropped, contents unchanged, overflow<=1 until reset.
//   - Push and pop in the same cycle are both performed; level is unchanged.
//     This also holds when full: no overflow, and the pushed entry goes to the tail.
//   - Push and pop in the same cycle when empty: push performed, pop ignored; rd_valid=1 next cycle.
//   Arithmetic
//   - No sign processing; data is stored and returned bit-exact (signed interpretation
//     belongs to the core).
// TESTING
//   1 SW=8'h05 held, SW8=1 for 3 cycles, then 0
//     -> after 4 edges: rd_valid=1, rd_data=8'h05, level=1; exactly one entry.
//   2 Push 8'h05 then 8'hFB (-5); rd_en pulsed twice
//     -> rd_data 8'h05, then 8'hFB; rd_valid=0 and level=0 afterwards.
//   3 SW8 glitch high for 1 cycle (DEBOUNCE_CYCLES=2)
//     -> no push; level=0; overflow=0.
//   4 Three presses (8'h01, 8'h02, 8'h03) with no reads
//     -> level=2, overflow=1; reads return 8'h01, 8'h02 only.
//   5 FIFO full; rd_en=1 in the same cycle as push of 8'h07
//     -> level stays 2, overflow=0, order preserved with 8'h07 last.
//   6 reset=1 one cycle during debounce of a press with the FIFO holding one entry
//     -> rd_valid=0, level=0, overflow=0, no push after reset releases.

Source files
------------

// File: rtl/sw_input_port.sv
// Operand-entry front end: synchronises and debounces the enter button, captures the
// switch value on each accepted press and queues it in a small FIFO for the core.
module sw_input_port #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int DEPTH           = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           SW,
    input  logic                       SW8,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]       sw_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] b_sync;
    logic [WIDTH-1:0]       sw_s;
    logic                   b_s;
    logic                   deb;
    logic [CW-1:0]          cnt;
    logic                   push;
    logic                   pop;
    logic                   push_ok;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    assign sw_s = sw_sync[SYNC_STAGES-1];
    assign b_s  = b_sync[SYNC_STAGES-1];

    // Synchroniser chains for the switches and the enter button.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            b_sync <= '0;
        end else begin
            sw_sync[0] <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
            b_sync <= {b_sync[SYNC_STAGES-2:0], SW8};
        end
    end

    // Debounce: level follows b_s only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (b_s == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            deb <= b_s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Press/pop qualification; a pop makes room for a push even when full.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        push_ok = 1'b0;
        if ((b_s != deb) && (cnt == CNT_MAX) && b_s) begin
            push = 1'b1;
        end else begin
            push = 1'b0;
        end
        if (rd_en && (level != '0)) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
        if (push && ((level != FULL_LVL) || pop)) begin
            push_ok = 1'b1;
        end else begin
            push_ok = 1'b0;
        end
    end

    // Circular FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end else begin
                rd_ptr <= rd_ptr;
            end
            if (push_ok) begin
                mem[wr_ptr] <= sw_s;
                wr_ptr      <= wr_ptr + PW'(1);
            end else begin
                wr_ptr <= wr_ptr;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else begin
                overflow <= overflow;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (level != '0);

endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port: latency, ordering, glitch rejection, overflow,
// simultaneous push/pop and reset during debounce.
module tb_sw_input_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] SW;
    logic       SW8;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [1:0] level;
    logic       overflow;

    int total  = 0;
    int passed = 0;

    sw_input_port dut (
        .clk      (clk),
        .reset    (reset),
        .SW       (SW),
        .SW8      (SW8),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic [7:0] v);
        SW  = v;
        SW8 = 1'b1;
        cyc(3);
        SW8 = 1'b0;
        cyc(6);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", rd_valid); else passed++;
        total++; if (level !== 2'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", overflow); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_data got %h want 00", rd_data); else passed++;
    endtask

    task automatic test_single();
        SW  = 8'h05;
        SW8 = 1'b1;
        cyc(3);
        SW8 = 1'b0;
        total++; if (rd_valid !== 1'b0) $display("FAIL single_early got %0b want 0", rd_valid); else passed++;
        cyc(1);
        total++; if (rd_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", rd_valid); else passed++;
        total++; if (rd_data !== 8'h05) $display("FAIL single_data got %h want 05", rd_data); else passed++;
        total++; if (level !== 2'd1) $display("FAIL single_level got %0d want 1", level); else passed++;
        cyc(8);
        total++; if (level !== 2'd1) $display("FAIL single_once got %0d want 1", level); else passed++;
        pop();
        total++; if (rd_valid !== 1'b0) $display("FAIL single_pop got %0b want 0", rd_valid); else passed++;
    endtask

    task automatic test_two();
        press(8'h05);
        press(8'hFB);
        total++; if (level !== 2'd2) $display("FAIL two_level got %0d want 2", level); else passed++;
        total++; if (rd_data !== 8'h05) $display("FAIL two_first got %h want 05", rd_data); else passed++;
        pop();
        total++; if (rd_data !== 8'hFB) $display("FAIL two_second got %h want fb", rd_data); else passed++;
        total++; if (level !== 2'd1) $display("FAIL two_level1 got %0d want 1", level); else passed++;
        pop();
        total++; if (rd_valid !== 1'b0) $display("FAIL two_empty got %0b want 0", rd_valid); else passed++;
        total++; if (level !== 2'd0) $display("FAIL two_level0 got %0d want 0", level); else passed++;
        pop();
        total++; if (level !== 2'd0) $display("FAIL empty_pop got %0d want 0", level); else passed++;
    endtask

    task automatic test_glitch();
        SW  = 8'hAA;
        SW8 = 1'b1;
        cyc(1);
        SW8 = 1'b0;
        cyc(8);
        total++; if (level !== 2'd0) $display("FAIL glitch_level got %0d want 0", level); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL glitch_valid got %0b want 0", rd_valid); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL glitch_ovf got %0b want 0", overflow); else passed++;
    endtask

    task automatic test_overflow();
        press(8'h01);
        press(8'h02);
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %0b want 0", overflow); else passed++;
        press(8'h03);
        total++; if (level !== 2'd2) $display("FAIL ovf_level got %0d want 2", level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else passed++;
        total++; if (rd_data !== 8'h01) $display("FAIL ovf_first got %h want 01", rd_data); else passed++;
        pop();
        total++; if (rd_data !== 8'h02) $display("FAIL ovf_second got %h want 02", rd_data); else passed++;
        pop();
        total++; if (rd_valid !== 1'b0) $display("FAIL ovf_drained got %0b want 0", rd_valid); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else passed++;
        do_reset();
    endtask

    task automatic test_full_push_pop();
        press(8'h05);
        press(8'h06);
        SW  = 8'h07;
        SW8 = 1'b1;
        cyc(3);
        SW8 = 1'b0;
        total++; if (level !== 2'd2) $display("FAIL fpp_pre got %0d want 2", level); else passed++;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        total++; if (level !== 2'd2) $display("FAIL fpp_level got %0d want 2", level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fpp_ovf got %0b want 0", overflow); else passed++;
        total++; if (rd_data !== 8'h06) $display("FAIL fpp_head got %h want 06", rd_data); else passed++;
        cyc(6);
        pop();
        total++; if (rd_data !== 8'h07) $display("FAIL fpp_tail got %h want 07", rd_data); else passed++;
        pop();
        total++; if (rd_valid !== 1'b0) $display("FAIL fpp_empty got %0b want 0", rd_valid); else passed++;
    endtask

    task automatic test_empty_push_pop();
        SW  = 8'h80;
        SW8 = 1'b1;
        cyc(3);
        SW8   = 1'b0;
        rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1) $display("FAIL epp_valid got %0b want 1", rd_valid); else passed++;
        total++; if (rd_data !== 8'h80) $display("FAIL epp_data got %h want 80", rd_data); else passed++;
        total++; if (level !== 2'd1) $display("FAIL epp_level got %0d want 1", level); else passed++;
        cyc(6);
    endtask

    task automatic test_reset_mid();
        total++; if (level !== 2'd1) $display("FAIL rmid_pre got %0d want 1", level); else passed++;
        SW  = 8'h22;
        SW8 = 1'b1;
        cyc(3);
        reset = 1'b1;
        SW8   = 1'b0;
        cyc(1);
        reset = 1'b0;
        total++; if (rd_valid !== 1'b0) $display("FAIL rmid_valid got %0b want 0", rd_valid); else passed++;
        total++; if (level !== 2'd0) $display("FAIL rmid_level got %0d want 0", level); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rmid_ovf got %0b want 0", overflow); else passed++;
        cyc(8);
        total++; if (level !== 2'd0) $display("FAIL rmid_nopush got %0d want 0", level); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        SW    = 8'h00;
        SW8   = 1'b0;
        rd_en = 1'b0;
        cyc(1);
        test_reset();
        test_single();
        test_two();
        test_glitch();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
